// File: rtl/quadrature_encoder_counter.sv
// Quadrature encoder front end: per-pin synchroniser and glitch filter, 4x decoder, wrapping position.
// Optional index clear is built when QUAD_INDEX_EN is defined.
package quad_encoder_pkg;
   typedef enum logic [1:0] {
      DIR_NONE  = 2'd0,
      DIR_CW    = 2'd1,
      DIR_CCW   = 2'd2,
      DIR_BRAKE = 2'd3
   } rotation_direction_t;
endpackage

module quadrature_encoder_counter
   import quad_encoder_pkg::*;
#(
   parameter int counter_width = 32,
   parameter int filter_len    = 3,
   parameter int err_width     = 8
) (
   input  logic                     sys_clk,
   input  logic                     reset,
   input  logic                     enc_a,
   input  logic                     enc_b,
   input  logic                     enc_i,
   input  logic                     load,
   input  logic [counter_width-1:0] load_value,
   output logic [counter_width-1:0] position,
   output logic                     step,
   output rotation_direction_t      dir,
   output logic                     illegal,
   output logic [err_width-1:0]     err_count
);

`ifdef QUAD_INDEX_EN
   localparam int num_pins = 3;
`else
   localparam int num_pins = 2;
`endif

   localparam logic [7:0]               filt_max = 8'(filter_len - 1);
   localparam logic [counter_width-1:0] pos_one  = 1;
   localparam logic [err_width-1:0]     err_one  = 1;

   logic [num_pins-1:0] pin_raw;
   logic [num_pins-1:0] pin_filt;

`ifdef QUAD_INDEX_EN
   assign pin_raw = {enc_i, enc_b, enc_a};
`else
   logic unused_enc_i;
   assign pin_raw      = {enc_b, enc_a};
   assign unused_enc_i = enc_i;
`endif

   generate
      for (genvar gi = 0; gi < num_pins; gi++) begin : g_pin
         logic       sync1_reg;
         logic       sync2_reg;
         logic       filt_reg;
         logic [7:0] cnt_reg;

         // Filter adopts the synchronised value only after filter_len consecutive disagreeing samples.
         always_ff @(posedge sys_clk or posedge reset) begin
            if (reset) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               filt_reg  <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= pin_raw[gi];
               sync2_reg <= sync1_reg;
               if (sync2_reg == filt_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == filt_max) begin
                  filt_reg <= sync2_reg;
                  cnt_reg  <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
         end

         assign pin_filt[gi] = filt_reg;
      end
   endgenerate

   // Maps {A,B} onto its position in the CW cycle 00->10->11->01.
   function automatic logic [1:0] phase_of(input logic [1:0] ab);
      return {ab[0], ab[1] ^ ab[0]};
   endfunction

   logic [1:0] cur_ab;
   logic [1:0] prev_ab_reg;
   logic [1:0] delta;
   logic       is_cw;
   logic       is_ccw;
   logic       is_bad;
   logic       index_evt;

   assign cur_ab = {pin_filt[0], pin_filt[1]};

   always_comb begin
      delta  = phase_of(cur_ab) - phase_of(prev_ab_reg);
      is_cw  = (delta == 2'd1);
      is_ccw = (delta == 2'd3);
      is_bad = (delta == 2'd2);
   end

`ifdef QUAD_INDEX_EN
   logic prev_i_reg;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         prev_i_reg <= 1'b0;
      end else begin
         prev_i_reg <= pin_filt[2];
      end
   end

   assign index_evt = pin_filt[2] & ~prev_i_reg & (cur_ab == 2'b11);
`else
   assign index_evt = 1'b0;
`endif

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         prev_ab_reg <= 2'b00;
         position    <= '0;
         step        <= 1'b0;
         dir         <= DIR_NONE;
         illegal     <= 1'b0;
         err_count   <= '0;
      end else begin
         // History always advances so a step swallowed by load or index is never replayed.
         prev_ab_reg <= cur_ab;
         illegal     <= is_bad;
         step        <= (is_cw | is_ccw) & ~load & ~index_evt;
         if (is_bad && (err_count != '1)) begin
            err_count <= err_count + err_one;
         end
         if (load) begin
            position <= load_value;
         end else if (index_evt) begin
            position <= '0;
         end else if (is_cw) begin
            position <= position + pos_one;
            dir      <= DIR_CW;
         end else if (is_ccw) begin
            position <= position - pos_one;
            dir      <= DIR_CCW;
         end
      end
   end

endmodule
